booth_bist_controller: RTL and testbench
========================================

// Module: booth_bist_controller
// PURPOSE
//  Initiator side of the multiplier start/busy/product interface. Generates every
//  signed operand pair, issues start to the Booth multiplier under test, waits for
//  busy to complete, compares product against a golden signed product and reports
//  pass/fail. Replaces the hand-written stimulus for on-chip self test.
// PARAMETERS
//  WIDTH    4   operand width; product is 2*WIDTH bits; sweep = 2^(2*WIDTH) pairs
//  TIMEOUT  32  max cycles to wait for busy rise, or for busy fall; expiry = failure
// PORTS
//  clk          in   1        clock, all logic on rising edge
//  rst          in   1        synchronous reset, active-high
//  test_en      in   1        level; 1 = run/hold sweep, 0 = abort/idle
//  mul_a        out  WIDTH    operand a to multiplier (two's complement)
//  mul_b        out  WIDTH    operand b to multiplier (two's complement)
//  mul_start    out  1        one-cycle start pulse
//  mul_busy     in   1        multiplier busy
//  mul_product  in   2*WIDTH  multiplier result, valid when busy falls
//  done         out  1        sweep finished; held until test_en=0
//  pass         out  1        1 only when done=1 and err_count=0
//  err_count    out  8        mismatches + timeouts, saturates at 255
//  fail_a       out  WIDTH    mul_a of first failing pair (0 if none)
//  fail_b       out  WIDTH    mul_b of first failing pair (0 if none)
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, pair index 0, timer 0.
//  - Pair index idx (2*WIDTH bits): mul_a = idx[2W-1:W], mul_b = idx[W-1:0]; first
//    pair (0,0), last pair (all ones, all ones) = (-1,-1). Operands change only on
//    entry to ISSUE; held stable through CHECK.
//  - Golden = $signed(mul_a) * $signed(mul_b), full 2*WIDTH bits, sign-extended.
//  - FSM:
//    IDLE:      test_en=1 and done=0 -> ISSUE (idx=0, err_count=0, fail_a/b=0).
//    ISSUE:     mul_start=1 for exactly this cycle -> WAIT_BUSY, timer cleared.
//    WAIT_BUSY: mul_busy=1 -> WAIT_DONE (timer cleared); timer=TIMEOUT-1 -> CHECK
//               with timeout flag set.
//    WAIT_DONE: mul_busy=0 -> CHECK, register mul_product this cycle;
//               timer=TIMEOUT-1 -> CHECK with timeout flag set.
//    CHECK:     fail = timeout | (captured product != golden). On fail: err_count
//               +1 (saturating); if err_count was 0, load fail_a/fail_b. Then if
//               idx = all ones -> DONE, else idx+1 -> ISSUE.
//    DONE:      done=1, pass=(err_count==0); test_en=0 -> IDLE, done/pass cleared
//               (err_count, fail_a/b held until next run starts).
//  - Per pair latency: 1 (ISSUE) + busy-rise delay + busy duration + 1 (CHECK).
//  - test_en=0 in any state except IDLE: next cycle IDLE, mul_start=0, done=0,
//    pass=0; sweep restarts from idx 0 on next test_en=1.
//  - rst has priority over test_en and all transitions; rst mid-sweep -> reset
//    values next cycle, mul_start never left high.
//  - mul_busy high in IDLE/DONE is ignored. pass never 1 while done=0.
// TESTING
//  1 Correct model, busy 1 cycle after start, 3 cycles long, test_en=1 -> 256
//    start pulses, done=1, pass=1, err_count=0, fail_a=fail_b=0.
//  2 Model returns 8'h00 for a=4'b1000,b=4'b1000 (golden 8'h40) -> done=1, pass=0,
//    err_count=1, fail_a=4'b1000, fail_b=4'b1000.
//  3 Model never asserts busy -> every pair times out; done=1, pass=0,
//    err_count=255 (saturated), fail_a=0, fail_b=0.
//  4 Drop test_en at pair 100 -> next cycle IDLE, mul_start=0, done=0; re-raise ->
//    first start shows mul_a=0, mul_b=0.
//  5 Assert rst during WAIT_DONE -> next cycle all outputs 0; release with test_en=1
//    -> full sweep passes as in 1.
//  6 Mixed-sign check: a=4'b0111,b=4'b1001 (7*-7) with correct model -> product
//    8'hCF accepted, err_count unchanged.

Source files
------------

// File: rtl/booth_bist_controller_if.sv
// Start/busy/product link between the BIST controller (master) and the multiplier under test.
// Handshake: mul_start is a one-cycle request carrying mul_a/mul_b (held until the pair is checked); the
// multiplier acknowledges by raising mul_busy, and mul_product is valid in the cycle mul_busy is seen low again.
interface booth_bist_controller_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0]   mul_a;
  logic [WIDTH-1:0]   mul_b;
  logic               mul_start;
  logic               mul_busy;
  logic [2*WIDTH-1:0] mul_product;

  modport master (
    output mul_a, mul_b, mul_start,
    input  mul_busy, mul_product
  );

  modport slave (
    input  mul_a, mul_b, mul_start,
    output mul_busy, mul_product
  );
endinterface

// File: rtl/booth_bist_controller.sv
// Exhaustive signed-operand self test for a start/busy Booth multiplier: sweeps every pair,
// checks each product against a golden signed product and reports pass/fail.
module booth_bist_controller #(
  parameter int WIDTH   = 4,
  parameter int TIMEOUT = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       test_en,
  booth_bist_controller_if.master    mul,
  output logic                       done,
  output logic                       pass,
  output logic [7:0]                 err_count,
  output logic [WIDTH-1:0]           fail_a,
  output logic [WIDTH-1:0]           fail_b,
  output logic [2:0]                 state_dbg
);

  localparam int PW = 2 * WIDTH;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT - 1);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] ISSUE     = 3'd1;
  localparam logic [2:0] WAIT_BUSY = 3'd2;
  localparam logic [2:0] WAIT_DONE = 3'd3;
  localparam logic [2:0] CHECK     = 3'd4;
  localparam logic [2:0] DONE      = 3'd5;

  logic [2:0]    state;
  logic [PW-1:0] idx;
  logic [TW-1:0] timer;
  logic          timed_out;
  logic [PW-1:0] product_q;
  logic [PW-1:0] a_ext;
  logic [PW-1:0] b_ext;
  logic [PW-1:0] golden;
  logic          mismatch;

  // Operands come straight from the pair index, which only moves on entry to ISSUE.
  assign mul.mul_a     = idx[PW-1:WIDTH];
  assign mul.mul_b     = idx[WIDTH-1:0];
  assign mul.mul_start = (state == ISSUE);
  assign done          = (state == DONE);
  assign pass          = done && (err_count == 8'd0);
  assign state_dbg     = state;

  // Sign-extended operands multiplied modulo 2^PW give the exact signed product.
  always_comb begin
    a_ext    = {{WIDTH{mul.mul_a[WIDTH-1]}}, mul.mul_a};
    b_ext    = {{WIDTH{mul.mul_b[WIDTH-1]}}, mul.mul_b};
    golden   = a_ext * b_ext;
    mismatch = timed_out || (product_q != golden);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      timer     <= '0;
      timed_out <= 1'b0;
      product_q <= '0;
      err_count <= 8'd0;
      fail_a    <= '0;
      fail_b    <= '0;
    end else if (!test_en && (state != IDLE)) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (test_en) begin
            state     <= ISSUE;
            idx       <= '0;
            err_count <= 8'd0;
            fail_a    <= '0;
            fail_b    <= '0;
          end
        end
        ISSUE: begin
          state     <= WAIT_BUSY;
          timer     <= '0;
          timed_out <= 1'b0;
        end
        WAIT_BUSY: begin
          if (mul.mul_busy) begin
            state <= WAIT_DONE;
            timer <= '0;
          end else if (timer == TIMER_MAX) begin
            state     <= CHECK;
            timed_out <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!mul.mul_busy) begin
            state     <= CHECK;
            product_q <= mul.mul_product;
          end else if (timer == TIMER_MAX) begin
            state     <= CHECK;
            timed_out <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        CHECK: begin
          if (mismatch) begin
            if (err_count != 8'hFF) err_count <= err_count + 8'd1;
            if (err_count == 8'd0) begin
              fail_a <= mul.mul_a;
              fail_b <= mul.mul_b;
            end
          end
          if (&idx) begin
            state <= DONE;
          end else begin
            idx   <= idx + 1'b1;
            state <= ISSUE;
          end
        end
        DONE:    state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_bist_controller.sv
// Bench for booth_bist_controller: behavioural multiplier model, operand-order and result scoreboards.
module tb_booth_bist_controller;
  localparam int W = 4;
  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WAIT_DONE = 3'd3;
  localparam logic [2:0] S_CHECK     = 3'd4;

  logic clk = 1'b0;
  logic rst;
  logic test_en;
  logic done;
  logic pass;
  logic [7:0] err_count;
  logic [W-1:0] fail_a;
  logic [W-1:0] fail_b;
  logic [2:0] state_dbg;

  booth_bist_controller_if #(.WIDTH(W)) mul ();

  booth_bist_controller #(.WIDTH(W), .TIMEOUT(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .test_en   (test_en),
    .mul       (mul),
    .done      (done),
    .pass      (pass),
    .err_count (err_count),
    .fail_a    (fail_a),
    .fail_b    (fail_b),
    .state_dbg (state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  logic [2*W-1:0] exp_q[$];   // operand pairs expected on successive start pulses
  logic [16:0]    res_q[$];   // {pass, err_count, fail_a, fail_b} expected at done
  int model_mode = 0;         // 0 correct, 1 wrong at (-8,-8), 2 never busy

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_sweep();
    exp_q.delete();
    for (int i = 0; i < 256; i++) exp_q.push_back(8'(i));
  endtask

  // ---------------- multiplier model ----------------
  logic signed [W-1:0]   sa;
  logic signed [W-1:0]   sb;
  logic signed [2*W-1:0] gp;

  initial begin
    mul.mul_busy    = 1'b0;
    mul.mul_product = '0;
    forever begin
      @(negedge clk);
      if (mul.mul_start && model_mode != 2) begin
        sa = mul.mul_a;
        sb = mul.mul_b;
        @(posedge clk);
        #1;
        gp = sa * sb;
        if (model_mode == 1 && sa == 4'sb1000 && sb == 4'sb1000) gp = '0;
        mul.mul_product = gp;
        mul.mul_busy    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        mul.mul_busy = 1'b0;
      end
    end
  end

  // ---------------- monitor ----------------
  logic done_prev = 1'b0;
  initial begin
    logic [2*W-1:0] e;
    logic [16:0]    r;
    forever begin
      @(negedge clk);
      if (mul.mul_start) begin
        if (exp_q.size() == 0) check("start_unexpected", 32'(mul.mul_start), 32'd0);
        else begin
          e = exp_q.pop_front();
          check("start_operands", 32'({mul.mul_a, mul.mul_b}), 32'(e));
        end
      end
      if (done && !done_prev) begin
        if (res_q.size() == 0) check("done_unexpected", 32'(done), 32'd0);
        else begin
          r = res_q.pop_front();
          check("result_pass_err_fail", 32'({pass, err_count, fail_a, fail_b}), 32'(r));
        end
      end
      done_prev = done;
    end
  end

  // ---------------- driver helpers ----------------
  task automatic wait_done(input int budget);
    int n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!done) check("done_timeout", 32'(done), 32'd1);
    @(negedge clk);
    check("starts_consumed", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_start(input logic [2*W-1:0] pair, input int budget);
    int n = 0;
    @(negedge clk);
    while (!(mul.mul_start && {mul.mul_a, mul.mul_b} == pair) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) check("start_timeout", 32'({mul.mul_a, mul.mul_b}), 32'(pair));
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget);
    int n = 0;
    while (state_dbg != s && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (state_dbg != s) check("state_timeout", 32'(state_dbg), 32'(s));
  endtask

  task automatic stop_and_idle();
    test_en = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    rst     = 1'b1;
    test_en = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'({done, pass, err_count, fail_a, fail_b, mul.mul_a, mul.mul_b, mul.mul_start}), 32'd0);
    check("reset_state", 32'(state_dbg), 32'(S_IDLE));
    rst = 1'b0;
    @(negedge clk);

    // Full passing sweep, with the mixed-sign pair 7 * -7 inspected on the way.
    model_mode = 0;
    push_sweep();
    res_q.push_back({1'b1, 8'd0, 4'h0, 4'h0});
    test_en = 1'b1;
    wait_start(8'h79, 4000);
    wait_state(S_CHECK, 100);
    check("mixed_sign_product", 32'(mul.mul_product), 32'h00CF);
    @(negedge clk);
    check("mixed_sign_err_unchanged", 32'(err_count), 32'd0);
    wait_done(12000);
    stop_and_idle();
    check("idle_done_pass_cleared", 32'({done, pass}), 32'd0);

    // One wrong product at (-8,-8).
    model_mode = 1;
    push_sweep();
    res_q.push_back({1'b0, 8'd1, 4'h8, 4'h8});
    test_en = 1'b1;
    wait_done(12000);
    stop_and_idle();
    check("idle_err_held", 32'({done, pass, err_count, fail_a, fail_b}), 32'({1'b0, 1'b0, 8'd1, 4'h8, 4'h8}));

    // Multiplier never responds: every pair times out, error count saturates.
    model_mode = 2;
    push_sweep();
    res_q.push_back({1'b0, 8'hFF, 4'h0, 4'h0});
    test_en = 1'b1;
    wait_done(12000);
    stop_and_idle();
    check("sat_err_held", 32'(err_count), 32'hFF);

    // Abort at pair 100, then restart from pair 0.
    model_mode = 0;
    push_sweep();
    test_en = 1'b1;
    wait_start(8'd100, 4000);
    test_en = 1'b0;
    @(negedge clk);
    check("abort_state_idle", 32'(state_dbg), 32'(S_IDLE));
    check("abort_start_done", 32'({mul.mul_start, done, pass}), 32'd0);
    exp_q.delete();
    repeat (10) @(negedge clk);
    push_sweep();
    res_q.push_back({1'b1, 8'd0, 4'h0, 4'h0});
    test_en = 1'b1;
    wait_start(8'h00, 10);
    check("restart_first_operands", 32'({mul.mul_a, mul.mul_b}), 32'd0);
    wait_done(12000);
    stop_and_idle();

    // Reset while waiting for the product, then a clean full sweep.
    push_sweep();
    test_en = 1'b1;
    @(negedge clk);
    wait_state(S_WAIT_DONE, 100);
    rst = 1'b1;
    @(negedge clk);
    check("midrun_reset_outputs", 32'({done, pass, err_count, fail_a, fail_b, mul.mul_a, mul.mul_b, mul.mul_start}), 32'd0);
    check("midrun_reset_state", 32'(state_dbg), 32'(S_IDLE));
    exp_q.delete();
    repeat (5) @(negedge clk);
    push_sweep();
    res_q.push_back({1'b1, 8'd0, 4'h0, 4'h0});
    rst = 1'b0;
    wait_done(12000);
    stop_and_idle();
    check("results_consumed", 32'(res_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
